// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ram_arbiter_pkg : RAM op/size encodings, arbiter states and alignment helper
// Rev 1.0
package ram_arbiter_pkg;

  localparam int RAM_ADDRW = 16;
  localparam int RAM_BYTE  = 8;
  localparam int RAM_DATAW = 8 * RAM_BYTE;
  localparam int ARB_NREQ  = 2;

  typedef enum logic [1:0] {
    RAM_NOP   = 2'd0,
    RAM_FETCH = 2'd1,
    RAM_STORE = 2'd2
  } ram_op_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_WORD = 2'd1,
    SIZE_LONG = 2'd2,
    SIZE_QUAD = 2'd3
  } ram_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } state_t;

  // Natural alignment: the low log2(size) address bits must be zero.
  function automatic logic aligned(input logic [2:0] addr_lo, input logic [1:0] size);
    case (size)
      SIZE_BYTE: aligned = 1'b1;
      SIZE_WORD: aligned = (addr_lo[0] == 1'b0);
      SIZE_LONG: aligned = (addr_lo[1:0] == 2'b00);
      default:   aligned = (addr_lo == 3'b000);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_rr_pick.sv
`default_nettype none
// ram_arbiter_rr_pick : round-robin winner selection among the requesting ports
// Rev 1.0
module ram_arbiter_rr_pick
  import ram_arbiter_pkg::*;
(
  input  logic [ARB_NREQ-1:0] req,
  input  logic                rr_ptr,
  output logic                winner,
  output logic                valid
);

  // Port 1 wins when it is the only requester or when the pointer favours it.
  always_comb begin
    valid  = |req;
    winner = req[1] & (~req[0] | rr_ptr);
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ram_arbiter : shares the single-port RAM between two requesters with
// round-robin arbitration and a fixed IDLE/ISSUE/RESP access sequence. Rev 1.0
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDRW = RAM_ADDRW,
  parameter int DATAW = RAM_DATAW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_req,
  input  logic [1:0]       r0_op,
  input  logic [1:0]       r0_size,
  input  logic [ADDRW-1:0] r0_addr,
  input  logic [DATAW-1:0] r0_wdata,
  output logic             r0_gnt,
  output logic             r0_done,
  output logic [DATAW-1:0] r0_rdata,
  output logic             r0_err,
  input  logic             r1_req,
  input  logic [1:0]       r1_op,
  input  logic [1:0]       r1_size,
  input  logic [ADDRW-1:0] r1_addr,
  input  logic [DATAW-1:0] r1_wdata,
  output logic             r1_gnt,
  output logic             r1_done,
  output logic [DATAW-1:0] r1_rdata,
  output logic             r1_err,
  output logic [1:0]       ram_op,
  output logic [1:0]       ram_size,
  output logic [ADDRW-1:0] ram_addr,
  output logic [DATAW-1:0] ram_data_in,
  input  logic [DATAW-1:0] ram_data_out
);

  state_t              state;
  logic                rr_ptr;
  logic                owner;
  logic                fetch_q;
  logic [ARB_NREQ-1:0] gnt_q;
  logic [ARB_NREQ-1:0] done_q;
  logic [ARB_NREQ-1:0] err_q;

  logic [ARB_NREQ-1:0] req;
  logic                winner;
  logic                win_valid;
  logic [1:0]          win_op;
  logic [1:0]          win_size;
  logic [ADDRW-1:0]    win_addr;
  logic [DATAW-1:0]    win_wdata;

  assign req = {r1_req, r0_req};

  ram_arbiter_rr_pick u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  assign win_op    = winner ? r1_op    : r0_op;
  assign win_size  = winner ? r1_size  : r0_size;
  assign win_addr  = winner ? r1_addr  : r0_addr;
  assign win_wdata = winner ? r1_wdata : r0_wdata;

  // The ram_* registers double as the latched request of the current owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      fetch_q     <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      ram_op      <= RAM_NOP;
      ram_size    <= '0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      case (state)
        ARB_IDLE: begin
          if (win_valid) begin
            owner   <= winner;
            fetch_q <= (win_op == RAM_FETCH);
            if (aligned(win_addr[2:0], win_size)) begin
              state          <= ARB_ISSUE;
              gnt_q[winner]  <= 1'b1;
              ram_op         <= win_op;
              ram_size       <= win_size;
              ram_addr       <= win_addr;
              ram_data_in    <= win_wdata;
            end else begin
              err_q[winner]  <= 1'b1;
            end
          end
        end
        ARB_ISSUE: begin
          ram_op        <= RAM_NOP;
          done_q[owner] <= 1'b1;
          rr_ptr        <= ~owner;
          state         <= ARB_RESP;
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign r0_gnt  = gnt_q[0];
  assign r1_gnt  = gnt_q[1];
  assign r0_done = done_q[0];
  assign r1_done = done_q[1];
  assign r0_err  = err_q[0];
  assign r1_err  = err_q[1];

  // The RAM's own output register supplies fetch data during the RESP cycle.
  assign r0_rdata = (done_q[0] && fetch_q) ? ram_data_out : '0;
  assign r1_rdata = (done_q[1] && fetch_q) ? ram_data_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// tb_ram_arbiter : randomized scoreboard bench for ram_arbiter with a
// transaction-level reference model and a behavioural 1-cycle-latency RAM.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int K_GNT  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [63:0] wdata;
    int          gap;
  } txn_t;

  typedef struct {
    int          cyc;
    int          port;
    int          kind;
    logic [1:0]  op;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req;
  logic [1:0]  op    [2];
  logic [1:0]  size  [2];
  logic [15:0] addr  [2];
  logic [63:0] wdata [2];
  logic [1:0]  gnt, done, err;
  logic [63:0] rdata [2];
  logic [1:0]  ram_op, ram_size;
  logic [15:0] ram_addr;
  logic [63:0] ram_data_in;
  logic [63:0] ram_data_out = '0;

  logic [7:0] ram_mem [65536];
  logic [7:0] ref_mem [65536];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   free_at = 0;
  int   ptr   = 0;
  exp_t sb [$];
  txn_t q0 [$];
  txn_t q1 [$];
  int   gapc [2];

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(req[0]), .r0_op(op[0]), .r0_size(size[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_gnt(gnt[0]), .r0_done(done[0]), .r0_rdata(rdata[0]), .r0_err(err[0]),
    .r1_req(req[1]), .r1_op(op[1]), .r1_size(size[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_gnt(gnt[1]), .r1_done(done[1]), .r1_rdata(rdata[1]), .r1_err(err[1]),
    .ram_op(ram_op), .ram_size(ram_size), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, got, want, cyc);
    end
  endtask

  // Behavioural RAM: little-endian bytes, right-justified data, 1-cycle fetch latency.
  always @(posedge clk) begin
    if (ram_op == RAM_FETCH) begin
      logic [63:0] d;
      d = '0;
      for (int i = 0; i < (1 << ram_size); i++) d[8*i +: 8] = ram_mem[16'(ram_addr + 16'(i))];
      ram_data_out <= d;
    end else begin
      ram_data_out <= {$urandom, $urandom};
      if (ram_op == RAM_STORE)
        for (int i = 0; i < (1 << ram_size); i++) ram_mem[16'(ram_addr + 16'(i))] <= ram_data_in[8*i +: 8];
    end
  end

  // Reference model: an accepted access blocks the arbiter for three cycles,
  // a rejected one for a single cycle; ties go to ptr, which flips only on issue.
  task automatic model_accept();
    int   w, n;
    exp_t e;
    if (req == 2'b11) w = ptr;
    else              w = req[1] ? 1 : 0;
    n      = 1 << size[w];
    e.port = w;
    e.cyc  = cyc;
    e.op   = op[w];
    e.size = size[w];
    e.addr = addr[w];
    if (int'(addr[w]) % n != 0) begin
      e.kind = K_ERR;
      e.data = '0;
      sb.push_back(e);
      free_at = cyc + 1;
    end else begin
      e.kind = K_GNT;
      e.data = wdata[w];
      sb.push_back(e);
      e.kind = K_DONE;
      e.cyc  = cyc + 1;
      e.data = '0;
      if (op[w] == RAM_FETCH)
        for (int i = 0; i < n; i++) e.data[8*i +: 8] = ref_mem[16'(addr[w] + 16'(i))];
      if (op[w] == RAM_STORE)
        for (int i = 0; i < n; i++) ref_mem[16'(addr[w] + 16'(i))] = wdata[w][8*i +: 8];
      sb.push_back(e);
      free_at = cyc + 3;
      ptr     = 1 - w;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      ptr     = 0;
      free_at = 0;
    end else if (cyc >= free_at && req != 2'b00) begin
      model_accept();
    end
  end

  // Monitor: every pulse must match the head of the scoreboard in cycle, port and kind.
  initial begin
    logic [1:0]  xop;
    logic [63:0] xrd [2];
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk(1'b0, "missing_event", 64'd0, 64'(sb[0].port * 4 + sb[0].kind + 1));
        void'(sb.pop_front());
      end
      xop = RAM_NOP;
      xrd[0] = '0;
      xrd[1] = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        if (sb[0].kind == K_GNT)  xop = sb[0].op;
        if (sb[0].kind == K_DONE) xrd[sb[0].port] = sb[0].data;
      end
      chk(ram_op == xop, "ram_op", 64'(ram_op), 64'(xop));
      chk(rdata[0] == xrd[0], "r0_rdata", rdata[0], xrd[0]);
      chk(rdata[1] == xrd[1], "r1_rdata", rdata[1], xrd[1]);
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < 3; k++) begin
          logic pulse;
          bit   ok;
          pulse = (k == K_GNT) ? gnt[p] : ((k == K_DONE) ? done[p] : err[p]);
          if (pulse) begin
            ok = (sb.size() > 0) && (sb[0].cyc == cyc) && (sb[0].port == p) && (sb[0].kind == k);
            chk(ok, "event", 64'(p * 4 + k + 1),
                (sb.size() > 0) ? 64'(sb[0].port * 4 + sb[0].kind + 1) : 64'd0);
            if (ok) begin
              if (k == K_GNT) begin
                chk(ram_addr == sb[0].addr && ram_size == sb[0].size, "ram_addr_size",
                    64'({ram_size, ram_addr}), 64'({sb[0].size, sb[0].addr}));
                chk(ram_data_in == sb[0].data, "ram_data_in", ram_data_in, sb[0].data);
              end
              void'(sb.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic feed(input int p);
    txn_t t;
    bit   have;
    have = 1'b0;
    if (p == 0 && q0.size() > 0) begin t = q0[0]; have = 1'b1; end
    if (p == 1 && q1.size() > 0) begin t = q1[0]; have = 1'b1; end
    if (have) begin
      if (gapc[p] < t.gap) gapc[p]++;
      else begin
        gapc[p] = 0;
        if (p == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        req[p]   = 1'b1;
        op[p]    = t.op;
        size[p]  = t.size;
        addr[p]  = t.addr;
        wdata[p] = t.wdata;
      end
    end
  endtask

  // Requesters: hold req until gnt or err, then scramble the bus and move on.
  initial begin
    req = '0;
    for (int p = 0; p < 2; p++) begin
      op[p] = RAM_NOP; size[p] = '0; addr[p] = '0; wdata[p] = '0; gapc[p] = 0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!rst_n) req[p] = 1'b0;
        else begin
          if (req[p] && (gnt[p] || err[p])) begin
            req[p]  = 1'b0;
            op[p]   = 2'($urandom_range(0, 2));
            addr[p] = 16'($urandom);
          end
          if (!req[p]) feed(p);
        end
      end
    end
  end

  task automatic push(input int p, input logic [1:0] o, input logic [1:0] s,
                      input logic [15:0] a, input logic [63:0] d, input int g);
    txn_t t;
    t.op = o; t.size = s; t.addr = a; t.wdata = d; t.gap = g;
    if (p == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && req == 2'b00 && sb.size() == 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) chk(1'b0, "quiet_timeout", 64'(n), 64'(budget));
  endtask

  initial begin
    int n;
    logic [1:0]  o, s;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      ram_mem[i] = b;
      ref_mem[i] = b;
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] wv;
      wv = 32'h11223344;
      ram_mem[16 + i] = wv[8*i +: 8];
      ref_mem[16 + i] = wv[8*i +: 8];
    end

    repeat (3) @(negedge clk);
    chk(ram_op == RAM_NOP && ram_size == 2'd0 && ram_addr == 16'd0, "reset_ram_ctl",
        64'({ram_op, ram_size, ram_addr}), 64'd0);
    chk(ram_data_in == 64'd0, "reset_ram_data", ram_data_in, 64'd0);
    chk({gnt, done, err} == 6'd0, "reset_pulses", 64'({gnt, done, err}), 64'd0);
    chk(rdata[0] == 64'd0 && rdata[1] == 64'd0, "reset_rdata", rdata[0] | rdata[1], 64'd0);
    rst_n = 1'b1;

    push(0, RAM_FETCH, SIZE_LONG, 16'h0010, 64'd0, 0);
    wait_quiet(50);
    push(1, RAM_STORE, SIZE_BYTE, 16'h0021, 64'hAB, 0);
    wait_quiet(50);
    push(0, RAM_FETCH, SIZE_BYTE, 16'h0021, 64'd0, 0);
    wait_quiet(50);
    push(1, RAM_NOP, SIZE_QUAD, 16'h0040, 64'h5555, 0);
    wait_quiet(50);

    for (int i = 0; i < 2; i++) begin
      push(0, RAM_FETCH, SIZE_QUAD, 16'h0000, 64'd0, 0);
      push(1, RAM_FETCH, SIZE_QUAD, 16'h0008, 64'd0, 0);
    end
    wait_quiet(60);

    push(1, RAM_STORE, SIZE_QUAD, 16'h0003, 64'hDEAD, 0);
    wait_quiet(50);
    push(0, RAM_FETCH, SIZE_WORD, 16'h0100, 64'd0, 0);
    push(1, RAM_FETCH, SIZE_WORD, 16'h0200, 64'd0, 0);
    wait_quiet(50);
    push(1, RAM_STORE, SIZE_LONG, 16'h0006, 64'hBEEF, 0);
    wait_quiet(50);
    push(0, RAM_FETCH, SIZE_BYTE, 16'h0300, 64'd0, 0);
    push(1, RAM_FETCH, SIZE_BYTE, 16'h0301, 64'd0, 0);
    wait_quiet(50);

    push(0, RAM_NOP, SIZE_BYTE, 16'h0077, 64'h1234, 0);
    wait_quiet(50);

    for (int i = 0; i < 80; i++) begin
      o = 2'($urandom_range(0, 2));
      s = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      if (o == RAM_NOP) a = a & ~16'((1 << s) - 1);
      push(i % 2, o, s, a, {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end
    wait_quiet(2000);

    push(0, RAM_NOP, SIZE_BYTE, 16'h0000, 64'd0, 0);
    wait_quiet(50);
    push(1, RAM_FETCH, SIZE_QUAD, 16'h0008, 64'd0, 0);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (gnt[1]) break;
    end
    chk(gnt[1] == 1'b1, "abort_gnt_seen", 64'(gnt[1]), 64'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk(ram_op == RAM_NOP, "abort_ram_op", 64'(ram_op), 64'(RAM_NOP));
    chk({gnt, done, err} == 6'd0, "abort_pulses", 64'({gnt, done, err}), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk(done[1] == 1'b0, "abort_no_done", 64'(done[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, RAM_FETCH, SIZE_QUAD, 16'h0000, 64'd0, 0);
    push(1, RAM_FETCH, SIZE_QUAD, 16'h0008, 64'd0, 0);
    wait_quiet(50);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
